// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings and defaults for the CPU step/run advance controller.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned DefDivCount       = 100000000;
  localparam int unsigned DefDebounceCycles = 1000000;
  localparam int unsigned DefCntW           = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer producing a clean level.
module cpu_step_ctrl_sync_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q, sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return to the accepted level restarts the hold window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU advance-enable generator: free-run divider or debounced single-step, with halt.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DIV_COUNT       = DefDivCount,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             button,
  input  logic             run_sw,
  input  logic             halt_req,
  output logic             cpu_tick,
  output logic             running,
  output logic             halted,
  output logic             btn_level,
  output logic [CNT_W-1:0] tick_count
);

  localparam int unsigned     DivW   = cnt_width(DIV_COUNT);
  localparam logic [DivW-1:0] DivMax = DivW'(DIV_COUNT - 1);

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             running_q, halted_q;
  logic             run_meta_q, run_sync_q;
  logic             lvl_prev_q, press_q;
  logic             btn_lvl;

  cpu_step_ctrl_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i  (CLK),
    .rst_i  (CLR),
    .d_i    (button),
    .level_o(btn_lvl)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_STEP;
      div_q      <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == ST_RUN);
      halted_q   <= (state_d == ST_HALT);
      run_meta_q <= run_sw;
      run_sync_q <= run_meta_q;
      lvl_prev_q <= btn_lvl;
      press_q    <= btn_lvl & ~lvl_prev_q;
    end
  end

  // Halt beats mode change, mode change beats any tick source.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    unique case (state_q)
      ST_STEP: begin
        if (halt_req) begin
          state_d = ST_HALT;
          div_d   = '0;
        end else if (run_sync_q) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          tick_d = press_q;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          div_d   = '0;
        end else if (!run_sync_q) begin
          state_d = ST_STEP;
          div_d   = '0;
        end else if (div_q == DivMax) begin
          div_d  = '0;
          tick_d = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      ST_HALT: begin
        div_d = '0;
        if (press_q && !halt_req) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_STEP;
        div_d   = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tick_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cpu_tick   = tick_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign btn_level  = btn_lvl;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV_COUNT=5, DEBOUNCE_CYCLES=4, CNT_W=4.
module tb_cpu_step_ctrl;

  localparam int unsigned DivCount  = 5;
  localparam int unsigned DebCycles = 4;
  localparam int unsigned CntW      = 4;

  logic            clk = 1'b0;
  logic            clr, button, run_sw, halt_req;
  logic            cpu_tick, running, halted, btn_level;
  logic [CntW-1:0] tick_count;

  int n_pass  = 0;
  int n_total = 0;

  cpu_step_ctrl #(
    .DIV_COUNT      (DivCount),
    .DEBOUNCE_CYCLES(DebCycles),
    .CNT_W          (CntW)
  ) dut (
    .CLK       (clk),
    .CLR       (clr),
    .button    (button),
    .run_sw    (run_sw),
    .halt_req  (halt_req),
    .cpu_tick  (cpu_tick),
    .running   (running),
    .halted    (halted),
    .btn_level (btn_level),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  // One row per clock cycle: inputs for the cycle and the outputs expected in it.
  typedef struct {
    logic       b;
    logic       r;
    logic       h;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic b, input logic r, input logic h,
                       input logic tick, input logic lvl, input logic run, input logic hlt,
                       input int cnt);
    vec_t v;
    v.b   = b;
    v.r   = r;
    v.h   = h;
    v.exp = {tick, lvl, run, hlt, 4'(cnt)};
    repeat (n) vecs.push_back(v);
  endtask

  function automatic logic [7:0] outs();
    return {cpu_tick, btn_level, running, halted, tick_count};
  endfunction

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   c;
    logic bb, ll;

    // Step mode: clean press, release, second press.
    add_n(6, 1, 0, 0, 0, 0, 0, 0, 0);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 0);
    add_n(1, 1, 0, 0, 1, 1, 0, 0, 0);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 1);
    add_n(6, 0, 0, 0, 0, 1, 0, 0, 1);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 1);
    add_n(6, 1, 0, 0, 0, 0, 0, 0, 1);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 1);
    add_n(1, 1, 0, 0, 1, 1, 0, 0, 1);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 2);
    // Bounce: release, 2-cycle pulses, then a stable hold.
    add_n(6, 0, 0, 0, 0, 1, 0, 0, 2);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 2);
    add_n(2, 1, 0, 0, 0, 0, 0, 0, 2);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 2);
    add_n(2, 1, 0, 0, 0, 0, 0, 0, 2);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 2);
    add_n(6, 1, 0, 0, 0, 0, 0, 0, 2);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 2);
    add_n(1, 1, 0, 0, 1, 1, 0, 0, 2);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 3);
    add_n(6, 0, 0, 0, 0, 1, 0, 0, 3);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 3);
    // Run mode: 17 ticks with period 5, counter wraps, a press is ignored.
    add_n(3, 0, 1, 0, 0, 0, 0, 0, 3);
    add_n(5, 0, 1, 0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < 5; j++) begin
        c  = 73 + 5 * i + j;
        bb = (c >= 83 && c <= 97);
        ll = (c >= 89 && c <= 103);
        add_n(1, bb, 1, 0, (j == 0), ll, 1, 0, (j == 0) ? (3 + i) % 16 : (4 + i) % 16);
      end
    end
    // Halt raised on the divider's last count, press while halted, exit, step.
    add_n(1, 0, 1, 0, 1, 0, 1, 0, 4);
    add_n(3, 0, 1, 0, 0, 0, 1, 0, 5);
    add_n(1, 0, 1, 1, 0, 0, 1, 0, 5);
    add_n(3, 0, 1, 1, 0, 0, 0, 1, 5);
    add_n(6, 1, 0, 1, 0, 0, 0, 1, 5);
    add_n(4, 1, 0, 1, 0, 1, 0, 1, 5);
    add_n(6, 0, 0, 1, 0, 1, 0, 1, 5);
    add_n(2, 0, 0, 0, 0, 0, 0, 1, 5);
    add_n(6, 1, 0, 0, 0, 0, 0, 1, 5);
    add_n(2, 1, 0, 0, 0, 1, 0, 1, 5);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 5);
    add_n(6, 0, 0, 0, 0, 1, 0, 0, 5);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 5);
    add_n(6, 1, 0, 0, 0, 0, 0, 0, 5);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 5);
    add_n(1, 1, 0, 0, 1, 1, 0, 0, 5);
    add_n(2, 1, 0, 0, 0, 1, 0, 0, 6);
    add_n(6, 0, 0, 0, 0, 1, 0, 0, 6);
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 6);
    // run_sw dropped so the synced value falls on the divider's last count.
    add_n(3, 0, 1, 0, 0, 0, 0, 0, 6);
    add_n(5, 0, 1, 0, 0, 0, 1, 0, 6);
    add_n(1, 0, 1, 0, 1, 0, 1, 0, 6);
    add_n(1, 0, 1, 0, 0, 0, 1, 0, 7);
    add_n(3, 0, 0, 0, 0, 0, 1, 0, 7);
    add_n(3, 0, 0, 0, 0, 0, 0, 0, 7);

    // Reset holds everything at zero even with inputs active.
    clr      = 1'b1;
    button   = 1'b1;
    run_sw   = 1'b1;
    halt_req = 1'b1;
    repeat (3) cyc();
    chk8("reset_state", outs(), 8'h00);
    button   = 1'b0;
    run_sw   = 1'b0;
    halt_req = 1'b0;
    clr      = 1'b0;

    foreach (vecs[i]) begin
      button   = vecs[i].b;
      run_sw   = vecs[i].r;
      halt_req = vecs[i].h;
      if (outs() !== vecs[i].exp) begin
        $display("FAIL vec[%0d]: got %b expected %b (tick,lvl,run,hlt,cnt)", i, outs(),
                 vecs[i].exp);
      end else begin
        n_pass++;
      end
      n_total++;
      cyc();
    end

    // Reset mid-debounce: hold counter at 2, then clear.
    button = 1'b1;
    repeat (4) cyc();
    clr = 1'b1;
    #1;
    chk8("clr_mid_debounce", outs(), 8'h00);
    button = 1'b0;
    repeat (2) cyc();
    chk8("clr_held", outs(), 8'h00);

    // Debounce restarts from scratch after reset.
    clr    = 1'b0;
    button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk1($sformatf("post_clr_lvl_c%0d", k), btn_level, (k >= 6));
      chk1($sformatf("post_clr_tick_c%0d", k), cpu_tick, (k == 8));
    end
    cyc();
    chk8("post_clr_count", {4'd0, tick_count}, 8'd1);

    // Enter RUN, reset with divider at 3.
    button = 1'b0;
    run_sw = 1'b1;
    for (int k = 10; k <= 15; k++) begin
      cyc();
      chk1($sformatf("rerun_running_c%0d", k), running, (k >= 12));
      chk1($sformatf("rerun_tick_c%0d", k), cpu_tick, 1'b0);
    end
    clr = 1'b1;
    #1;
    chk8("clr_mid_run", outs(), 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk1($sformatf("clr_no_tick_%0d", k), cpu_tick, 1'b0);
    end

    // First RUN tick comes 5 cycles after re-entry.
    clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk1($sformatf("reentry_running_c%0d", k), running, (k >= 3));
      chk1($sformatf("reentry_tick_c%0d", k), cpu_tick, (k == 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
